// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the single-port memory.
// slave: arbiter view; master: requesters plus memory (the bench side).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_rw, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_rw, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for two masters sharing a single-port data memory; 1-cycle read latency.
// Optional grant locking is compiled in with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);
  logic              last_gnt;  // 0: m0 won last, 1: m1 won last
  logic              gnt0, gnt1;
  logic              lock0_win, lock1_win;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              rw_sel;

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic [1:0] {FREE, LOCK0, LOCK1} lock_state_e;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  lock_state_e      lock_st;
  logic [CNT_W-1:0] lock_cnt;

  assign lock0_win = (lock_st == LOCK0) && bus.m0_req;
  assign lock1_win = (lock_st == LOCK1) && bus.m1_req;

  // Lock ends on release, on dropped request, or after LOCK_MAX grants; last_gnt then
  // points at the holder so the waiting port wins the following tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_st  <= FREE;
      lock_cnt <= '0;
    end else begin
      case (lock_st)
        FREE: begin
          if (gnt0 && bus.m0_lock && LOCK_MAX > 1) begin
            lock_st  <= LOCK0;
            lock_cnt <= CNT_W'(1);
          end else if (gnt1 && bus.m1_lock && LOCK_MAX > 1) begin
            lock_st  <= LOCK1;
            lock_cnt <= CNT_W'(1);
          end
        end
        LOCK0: begin
          if (!bus.m0_req || !bus.m0_lock || lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
            lock_st  <= FREE;
            lock_cnt <= '0;
          end else lock_cnt <= lock_cnt + 1'b1;
        end
        LOCK1: begin
          if (!bus.m1_req || !bus.m1_lock || lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
            lock_st  <= FREE;
            lock_cnt <= '0;
          end else lock_cnt <= lock_cnt + 1'b1;
        end
        default: begin
          lock_st  <= FREE;
          lock_cnt <= '0;
        end
      endcase
    end
  end
`else
  localparam int unused_lock_max = LOCK_MAX;
  logic unused_lock;
  assign unused_lock = bus.m0_lock ^ bus.m1_lock;
  assign lock0_win   = 1'b0;
  assign lock1_win   = 1'b0;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (lock0_win)                       gnt0 = 1'b1;
      else if (lock1_win)                  gnt1 = 1'b1;
      else if (bus.m0_req && bus.m1_req) begin
        gnt0 = last_gnt;
        gnt1 = !last_gnt;
      end else begin
        gnt0 = bus.m0_req;
        gnt1 = bus.m1_req;
      end
    end
  end

  always_comb begin
    rw_sel    = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    if (gnt0) begin
      rw_sel    = bus.m0_we;
      addr_sel  = bus.m0_addr;
      wdata_sel = bus.m0_wdata;
    end else if (gnt1) begin
      rw_sel    = bus.m1_we;
      addr_sel  = bus.m1_addr;
      wdata_sel = bus.m1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt  <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      if (gnt0)      last_gnt <= 1'b0;
      else if (gnt1) last_gnt <= 1'b1;
      rvalid0_q <= gnt0 && !bus.m0_we;
      rvalid1_q <= gnt1 && !bus.m1_we;
      if (gnt0 && !bus.m0_we) rdata0_q <= bus.mem_rdata;
      if (gnt1 && !bus.m1_we) rdata1_q <= bus.mem_rdata;
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.mem_rw    = rw_sel;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the single-port data memory.
- Port m0 is the core load/store unit; port m1 is the DMA/debug master.
- Grants at most one access per cycle and drives the memory's rw/addr/wdata. The memory's combinational read data is registered and returned to the granted reader with one-cycle latency.
- Ties are broken round-robin.

Parameters:
- ADDR_W, 10, memory word-address width.
- DATA_W, 32, data width.
- LOCK_MAX, 8, maximum consecutive locked grants. Used only with DMEM_ARB_LOCK_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- m0_req  in  1  m0 access request; held until granted
- m0_we  in  1  1=write, 0=read
- m0_addr  in  ADDR_W  word address
- m0_wdata  in  DATA_W  write data
- m0_lock  in  1  request grant retention (used only with DMEM_ARB_LOCK_EN)
- m0_gnt  out  1  access performed this cycle
- m0_rvalid  out  1  read data valid
- m0_rdata  out  DATA_W  read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_rvalid, m1_rdata: same as m0
- mem_rw  out  1  1=write, 0=read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  combinational read data from memory

Behaviour:
- Reset (rst=1 at posedge):
  - m0_rvalid=m1_rvalid=0; m0_rdata=m1_rdata=0.
  - last_gnt=1, so m0 wins the first tie.
  - Lock state returns to FREE; lock counter cleared.
  - While rst=1, gnt outputs=0 and mem_rw=0.
  - Reset mid-operation discards any pending rvalid. No write is issued in a cycle with rst=1.
- Arbitration is combinational in the request cycle:
  - Only one req high: that port is granted.
  - Both high: the port not equal to last_gnt is granted.
  - Neither high: no grant.
  - m0_gnt and m1_gnt are never high together.
- Transfer occurs on a cycle with req & gnt. The requester must keep we/addr/wdata stable while req=1 && gnt=0.
- last_gnt updates at the posedge after any grant.
- Memory drive:
  - Granted port: its we/addr/wdata pass straight through.
  - Idle: mem_rw=0, mem_addr=0, mem_wdata=0.
- Write: the memory captures the data at the posedge ending the grant cycle. No rvalid is produced.
- Read:
  - At the posedge ending the grant cycle, mem_rdata is registered into mX_rdata and mX_rvalid=1.
  - rvalid is a single-cycle pulse. rdata holds its value until the next read response.
- Back-to-back:
  - The same port may be granted on consecutive cycles when it alone requests.
  - rvalid for the grant in cycle N appears in cycle N+1, concurrent with the grant of cycle N+1.
- Read-after-write to the same address in consecutive grants returns the new data.
- Contention fairness:
  - With both ports requesting continuously, grants alternate m0, m1, m0, ...
  - No requester waits more than 1 cycle (without lock).

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- Defined: states FREE, LOCK0, LOCK1 plus a lock counter sized to hold LOCK_MAX.
  - FREE -> LOCKx when port x is granted with mX_lock=1; counter set to 1.
  - In LOCKx, port x wins every cycle it requests, regardless of the other port; counter increments per grant.
  - LOCKx -> FREE when mX_lock=0, mX_req=0, or counter reaches LOCK_MAX.
  - When the counter limit forces FREE and the other port is requesting, the other port is granted next cycle, regardless of last_gnt.
  - Reset -> FREE.
- Undefined: lock ports exist but are ignored; pure round-robin; no lock state or counter is synthesized.

Test Plan:
- Single write then read by m0: write addr 0x010 data 0xDEADBEEF (m0_gnt same cycle) -> next cycle read addr 0x010 -> m0_rvalid=1 with 0xDEADBEEF one cycle later.
- Simultaneous reads, m0 addr 0x001 (=0x11111111), m1 addr 0x002 (=0x22222222), both held 4 cycles -> grants m0, m1, m0, m1; rdata per port correct; never both gnt.
- m1 writes 0x5 to addr 0x3FF while m0 reads addr 0x3FF in the next cycle -> m0_rdata=0x5; m0 stalled exactly 1 cycle by the write.
- rst asserted in the cycle after a granted read -> rvalid stays 0; after release, first tie is granted to m0.
- Idle: no req for 3 cycles -> mem_rw=0, mem_addr=0, no gnt, no rvalid.
- With DMEM_ARB_LOCK_EN, LOCK_MAX=4: m0 holds lock+req and m1 requests -> m0 granted 4 cycles, then m1 granted; without the macro the same stimulus alternates.
